seqgen_arbiter: RTL and testbench
=================================

SEQGEN_ARBITER -- requirements
Module: seqgen_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning RUN-state cycles per grant (legal 1..8).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port req  input  4  per-requester request for the shared sequence generator.
REQ-005 The block SHALL have port x_req  input  4  per-requester X bit to drive into the generator.
REQ-006 The block SHALL have port gnt  output  4  one-hot grant, all-zero when nobody is granted.
REQ-007 The block SHALL have port gen_x  output  1  X input of the shared generator.
REQ-008 The block SHALL have port gen_clr  output  1  one-cycle clear to the shared generator.
REQ-009 The block SHALL have port done  output  4  one-cycle end-of-burst pulse to the granted requester.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port cnt  output  3  RUN-cycle index 0..BURST_LEN-1, 0 outside RUN.

Function
REQ-012 The FSM SHALL have states IDLE, CLEAR, RUN and DONE, plus a 2-bit round-robin pointer ptr and a 2-bit winner register w.
REQ-013 In IDLE with req != 0, the FSM SHALL latch w at the edge and go to CLEAR.
- w = first asserted req index searching ptr, ptr+1, ... mod 4.
REQ-014 In IDLE with req == 0, the FSM SHALL stay in IDLE.
- Outputs in IDLE: gnt=0, gen_x=0, gen_clr=0, done=0.
REQ-015 CLEAR SHALL last exactly one cycle.
- Outputs: gen_clr=1, gnt=onehot(w), gen_x=0.
- Next state: RUN with cnt=0.
REQ-016 In RUN, outputs SHALL be gnt=onehot(w) and gen_x=x_req[w], combinationally, with cnt incrementing each cycle.
REQ-017 RUN SHALL go to DONE at the edge where cnt==BURST_LEN-1, giving exactly BURST_LEN RUN cycles.
REQ-018 If req[w] is sampled low in CLEAR or RUN, the FSM SHALL go to DONE at that edge (early release).
REQ-019 DONE SHALL last exactly one cycle.
- Outputs: done[w]=1, gnt=0, gen_x=0.
- At exit: ptr = w+1 mod 4; next state IDLE.
REQ-020 Changes on req from non-granted requesters during CLEAR, RUN or DONE SHALL NOT affect the current burst.
REQ-021 gnt, done and gen_clr SHALL never have more than one bit set, and gnt and done SHALL never be nonzero in the same cycle.
REQ-022 Minimum spacing between two grants SHALL be one IDLE cycle.
- Request-to-first-RUN latency from IDLE: 2 edges.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, ptr=0, w=0, cnt=0 and all outputs to 0, including mid-burst.
REQ-024 A burst interrupted by rst SHALL NOT produce a done pulse.
- The first arbitration after rst deassertion SHALL search from index 0.

Configuration
REQ-025 With macro SEQGEN_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest asserted index wins, and ptr SHALL be held at 0.
REQ-026 Without SEQGEN_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-013/REQ-019.

Verification
REQ-027 Scenario 1: req=0001, x_req=0001, BURST_LEN=4 after reset.
- Response: CLEAR 1 cycle (gen_clr=1, gnt=0001), RUN 4 cycles (gen_x=1, cnt 0,1,2,3), DONE with done=0001, then IDLE.
REQ-028 Scenario 2: req=1111 held continuously, default build.
- Response: grant order 0001,0010,0100,1000,0001; each burst 6 cycles plus 1 IDLE.
REQ-029 Scenario 3: same as Scenario 2 with SEQGEN_ARB_FIXED_PRIO_EN defined.
- Response: every grant is 0001.
REQ-030 Scenario 4: req=0100, req[2] dropped at RUN cnt=1.
- Response: DONE next cycle with done=0100, ptr=3, no further RUN cycles.
REQ-031 Scenario 5: rst pulsed at RUN cnt=2 for grantee 2.
- Response: gnt=0000, busy=0, done=0000 immediately; with req=0101 after release, next grant is 0001.
REQ-032 Scenario 6: req=0010 held, x_req[1] toggled every cycle during RUN, req[3] asserted mid-burst.
- Response: gen_x follows x_req[1] same cycle; gnt stays 0010 until DONE; next grant is 1000.

Source files
------------

// File: rtl/seqgen_arbiter.sv
// seqgen_arbiter: arbitrates four requesters onto one shared sequence generator.
// Each grant is a burst of CLEAR (one cycle), then up to BURST_LEN RUN cycles, then DONE (one cycle).
// Ports: clk, rst (async, active-high); req/x_req per requester;
// gnt (one-hot grant); gen_x and gen_clr drive the shared generator;
// done is a one-hot end-of-burst pulse; busy is high outside IDLE;
// cnt is the RUN-cycle index.
// Build option: SEQGEN_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// in place of round-robin.
module seqgen_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] x_req,
  output logic [3:0] gnt,
  output logic       gen_x,
  output logic       gen_clr,
  output logic [3:0] done,
  output logic       busy,
  output logic [2:0] cnt
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t state, nxt;
  logic [1:0] ptr, w, pick, ptr_nxt;
  logic [3:0] onehot;
  // Offsets are scanned from farthest to nearest, so the nearest asserted index from ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
  end
`ifdef SEQGEN_ARB_FIXED_PRIO_EN
  assign ptr_nxt = 2'd0;
`else
  assign ptr_nxt = w + 2'd1;
`endif
  assign onehot = 4'b0001 << w;
  always_comb begin
    nxt = state;
    gnt = 4'b0;
    done = 4'b0;
    gen_x = 1'b0;
    gen_clr = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: nxt = |req ? CLEAR : IDLE;
      CLEAR: begin
        gnt = onehot;
        gen_clr = 1'b1;
        nxt = req[w] ? RUN : DONE;
      end
      RUN: begin
        gnt = onehot;
        gen_x = x_req[w];
        nxt = (!req[w] || cnt == 3'(BURST_LEN - 1)) ? DONE : RUN;
      end
      default: begin
        done = onehot;
        nxt = IDLE;
      end
    endcase
  end
  // cnt is cleared whenever the next state is not RUN, so it reads 0 outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd0;
      w <= 2'd0;
      cnt <= 3'd0;
    end else begin
      state <= nxt;
      cnt <= (state == RUN && nxt == RUN) ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && |req) w <= pick;
      if (state == DONE) ptr <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_seqgen_arbiter.sv
// tb_seqgen_arbiter: directed self-checking bench for seqgen_arbiter with BURST_LEN=4.
module tb_seqgen_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] x_req = 4'b0;
  logic [3:0] gnt, done;
  logic gen_x, gen_clr, busy;
  logic [2:0] cnt;
  int n_vec = 0;
  int n_err = 0;

  seqgen_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .x_req(x_req), .gnt(gnt),
    .gen_x(gen_x), .gen_clr(gen_clr), .done(done), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    x_req = 4'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL reset_done got %b exp 0000", done); end
    n_vec++; if ({busy, gen_clr, gen_x} !== 3'b0) begin n_err++; $display("FAIL reset_flags got %b exp 000", {busy, gen_clr, gen_x}); end
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_burst();
    do_reset();
    req = 4'b0001;
    x_req = 4'b0001;
    #1;
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL s1_idle_gnt got %b exp 0000", gnt); end
    tick();
    n_vec++; if ({gen_clr, gnt, gen_x, busy} !== 7'b1_0001_0_1) begin n_err++; $display("FAIL s1_clear got %b exp 1000101", {gen_clr, gnt, gen_x, busy}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if ({gen_clr, gnt, gen_x, cnt} !== {1'b0, 4'b0001, 1'b1, 3'(i)}) begin n_err++; $display("FAIL s1_run%0d got clr=%b gnt=%b x=%b cnt=%0d exp 0 0001 1 %0d", i, gen_clr, gnt, gen_x, cnt, i); end
    end
    tick();
    n_vec++; if ({done, gnt, busy, cnt} !== {4'b0001, 4'b0, 1'b1, 3'd0}) begin n_err++; $display("FAIL s1_done got done=%b gnt=%b busy=%b cnt=%0d exp 0001 0000 1 0", done, gnt, busy, cnt); end
    req = 4'b0;
    tick();
    n_vec++; if ({busy, done} !== 5'b0) begin n_err++; $display("FAIL s1_idle got busy=%b done=%b exp 0 0000", busy, done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    req = 4'b1111;
    x_req = 4'b0;
    for (int k = 0; k < 5; k++) begin
`ifdef SEQGEN_ARB_FIXED_PRIO_EN
      e = 4'b0001;
`else
      e = 4'b0001 << (k % 4);
`endif
      tick();
      n_vec++; if ({gen_clr, gnt} !== {1'b1, e}) begin n_err++; $display("FAIL rr%0d_clear got clr=%b gnt=%b exp 1 %b", k, gen_clr, gnt, e); end
      for (int i = 0; i < 4; i++) begin
        tick();
        n_vec++; if ({gnt, cnt} !== {e, 3'(i)}) begin n_err++; $display("FAIL rr%0d_run%0d got gnt=%b cnt=%0d exp %b %0d", k, i, gnt, cnt, e, i); end
      end
      tick();
      n_vec++; if ({done, gnt} !== {e, 4'b0}) begin n_err++; $display("FAIL rr%0d_done got done=%b gnt=%b exp %b 0000", k, done, gnt, e); end
      tick();
      n_vec++; if ({busy, gnt, done} !== 9'b0) begin n_err++; $display("FAIL rr%0d_idle got busy=%b gnt=%b done=%b exp 0", k, busy, gnt, done); end
    end
    req = 4'b0;
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    n_vec++; if ({gnt, cnt} !== {4'b0100, 3'd1}) begin n_err++; $display("FAIL er_run1 got gnt=%b cnt=%0d exp 0100 1", gnt, cnt); end
    req = 4'b0;
    tick();
    n_vec++; if ({done, gnt, busy} !== {4'b0100, 4'b0, 1'b1}) begin n_err++; $display("FAIL er_done got done=%b gnt=%b busy=%b exp 0100 0000 1", done, gnt, busy); end
    req = 4'b1001;
    tick();
    n_vec++; if ({busy, gnt} !== 5'b0) begin n_err++; $display("FAIL er_idle got busy=%b gnt=%b exp 0 0000", busy, gnt); end
    tick();
    n_vec++; if ({gen_clr, gnt} !== {1'b1, 4'b1000}) begin n_err++; $display("FAIL er_ptr3 got clr=%b gnt=%b exp 1 1000", gen_clr, gnt); end
    req = 4'b0001;
    tick();
    n_vec++; if ({done, cnt} !== {4'b1000, 3'd0}) begin n_err++; $display("FAIL er_clear_release got done=%b cnt=%0d exp 1000 0", done, cnt); end
    req = 4'b0;
    tick();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if ({gnt, cnt} !== {4'b0100, 3'd2}) begin n_err++; $display("FAIL rm_run2 got gnt=%b cnt=%0d exp 0100 2", gnt, cnt); end
    rst = 1'b1;
    #1;
    n_vec++; if ({gnt, busy, done, cnt} !== 12'b0) begin n_err++; $display("FAIL rm_async got gnt=%b busy=%b done=%b cnt=%0d exp all 0", gnt, busy, done, cnt); end
    tick();
    n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL rm_no_done got %b exp 0000", done); end
    req = 4'b0101;
    rst = 1'b0;
    tick();
    n_vec++; if ({gen_clr, gnt} !== {1'b1, 4'b0001}) begin n_err++; $display("FAIL rm_regrant got clr=%b gnt=%b exp 1 0001", gen_clr, gnt); end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_x_follow();
    do_reset();
    req = 4'b0010;
    x_req = 4'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) req = 4'b1010;
      x_req = 4'b1101;
      #1;
      n_vec++; if ({gen_x, gnt} !== {1'b0, 4'b0010}) begin n_err++; $display("FAIL xf%0d_lo got x=%b gnt=%b exp 0 0010", i, gen_x, gnt); end
      x_req = 4'b0010;
      #1;
      n_vec++; if (gen_x !== 1'b1) begin n_err++; $display("FAIL xf%0d_hi got x=%b exp 1", i, gen_x); end
    end
    tick();
    n_vec++; if ({done, gnt, gen_x} !== {4'b0010, 4'b0, 1'b0}) begin n_err++; $display("FAIL xf_done got done=%b gnt=%b x=%b exp 0010 0000 0", done, gnt, gen_x); end
    tick();
    tick();
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL xf_next got gnt=%b exp 1000", gnt); end
    req = 4'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_early_release();
    test_reset_midburst();
    test_x_follow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
